// File: rtl/cache_victim_buffer_pkg.sv
// Shared types and default geometry for the D$ victim (write-back) buffer.
package cache_victim_buffer_pkg;

  localparam int VB_PA_BITS   = 56;
  localparam int VB_LINELEN   = 512;
  localparam int VB_AHBW      = 64;
  localparam int VB_DEPTH     = 4;
  localparam int VB_BEATS     = VB_LINELEN / VB_AHBW;
  localparam int VB_BEAT_BITS = $clog2(VB_BEATS);
  localparam int VB_OFF_BITS  = $clog2(VB_LINELEN / 8);
  localparam int VB_PTR_W     = $clog2(VB_DEPTH) + 1;

  typedef enum logic {VB_IDLE, VB_WRITE} vb_state_t;

  typedef struct packed {
    logic                              valid;
    logic [VB_PA_BITS-1:VB_OFF_BITS]   adr;
    logic [VB_LINELEN-1:0]             line;
  } vb_entry_t;

endpackage

// File: rtl/cache_victim_buffer_cam.sv
// Tag CAM over the victim entries; one-hot select of the youngest valid match.
module victim_cam_match #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 50
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]            lookup_tag,
  input  logic [$clog2(DEPTH)-1:0]    head,
  output logic [DEPTH-1:0]            sel,
  output logic                        hit
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] idx;

  // Walk from oldest (head) to youngest; a later match overrides an earlier one.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + IDX_W'(k);
      if (valid[idx] && (tags[idx] == lookup_tag)) begin
        sel      = '0;
        sel[idx] = 1'b1;
      end
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/cache_victim_buffer.sv
// Victim write-back FIFO between D$ and bus: parks dirty lines, drains them in
// order one burst per line, yields to pending fills, forwards lines on lookup hit.
module cache_victim_buffer
  import cache_victim_buffer_pkg::*;
#(
  parameter int PA_BITS = VB_PA_BITS,
  parameter int LINELEN = VB_LINELEN,
  parameter int AHBW    = VB_AHBW,
  parameter int DEPTH   = VB_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              VictimValid,
  input  logic [PA_BITS-1:0]                VictimAdr,
  input  logic [LINELEN-1:0]                VictimLine,
  output logic                              VictimReady,
  input  logic [PA_BITS-1:0]                LookupAdr,
  output logic                              LookupHit,
  output logic [LINELEN-1:0]                LookupLine,
  input  logic                              FetchPending,
  input  logic                              DrainAll,
  output logic                              BusWrite,
  output logic [PA_BITS-1:0]                BusAdr,
  output logic [$clog2(LINELEN/AHBW)-1:0]   BusBeat,
  output logic [AHBW-1:0]                   BusWriteData,
  input  logic                              BusBeatAck,
  output logic                              Empty,
  output logic [$clog2(DEPTH):0]            Count
);

  localparam int BEATS    = LINELEN / AHBW;
  localparam int BEAT_W   = $clog2(BEATS);
  localparam int OFF_BITS = $clog2(LINELEN / 8);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int TAG_W    = PA_BITS - OFF_BITS;

  vb_entry_t                   entries [DEPTH];
  logic [PTR_W-1:0]            head, tail;
  logic [IDX_W-1:0]            head_idx, tail_idx;
  vb_state_t                   state;
  logic [BEAT_W-1:0]           beat;
  logic                        full, enq, pop, last_beat;
  logic [DEPTH-1:0]            ent_valid, sel;
  logic [DEPTH-1:0][TAG_W-1:0] ent_tags;
  logic                        unused_adr_bits;

  assign head_idx    = head[IDX_W-1:0];
  assign tail_idx    = tail[IDX_W-1:0];
  assign Count       = tail - head;
  assign Empty       = (Count == '0);
  assign full        = (Count == PTR_W'(DEPTH));
  // Readiness looks only at registered occupancy, so a pop this cycle frees nothing yet.
  assign VictimReady = ~full;
  assign enq         = VictimValid & ~full;
  assign last_beat   = (beat == BEAT_W'(BEATS - 1));
  assign pop         = (state == VB_WRITE) & BusBeatAck & last_beat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (pop) begin
        entries[head_idx].valid <= 1'b0;
        head                    <= head + PTR_W'(1);
      end
      if (enq) begin
        entries[tail_idx] <= '{valid: 1'b1, adr: VictimAdr[PA_BITS-1:OFF_BITS], line: VictimLine};
        tail              <= tail + PTR_W'(1);
      end
    end
  end

  // A started burst always runs to completion; only the start decision looks at FetchPending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= VB_IDLE;
      beat  <= '0;
    end else begin
      case (state)
        VB_IDLE: begin
          if (!Empty && (!FetchPending || full || DrainAll)) begin
            state <= VB_WRITE;
            beat  <= '0;
          end
        end
        VB_WRITE: begin
          if (BusBeatAck) begin
            if (last_beat) begin
              state <= VB_IDLE;
              beat  <= '0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: state <= VB_IDLE;
      endcase
    end
  end

  assign BusWrite     = (state == VB_WRITE);
  assign BusBeat      = beat;
  assign BusAdr       = BusWrite ? {entries[head_idx].adr, {OFF_BITS{1'b0}}} : '0;
  assign BusWriteData = BusWrite ? entries[head_idx].line[AHBW*beat +: AHBW] : '0;

  always_comb begin
    ent_valid = '0;
    ent_tags  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entries[i].valid;
      ent_tags[i]  = entries[i].adr;
    end
  end

  victim_cam_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_cam (
    .valid      (ent_valid),
    .tags       (ent_tags),
    .lookup_tag (LookupAdr[PA_BITS-1:OFF_BITS]),
    .head       (head_idx),
    .sel        (sel),
    .hit        (LookupHit)
  );

  always_comb begin
    LookupLine = '0;
    for (int i = 0; i < DEPTH; i++) LookupLine |= {LINELEN{sel[i]}} & entries[i].line;
  end

  assign unused_adr_bits = ^{VictimAdr[OFF_BITS-1:0], LookupAdr[OFF_BITS-1:0]};

endmodule

// File: tb/tb_cache_victim_buffer.sv
// Self-checking bench for cache_victim_buffer: table-driven status checks plus a bus scoreboard.
module tb_cache_victim_buffer;

  localparam int PA = 56;
  localparam int LL = 512;
  localparam int BW = 64;
  localparam int NB = 8;

  localparam logic [PA-1:0] ADR_A = 56'h8000_0040;
  localparam logic [PA-1:0] ADR_B = 56'h8000_0080;
  localparam logic [PA-1:0] ADR_C = 56'h8000_00C0;
  localparam logic [PA-1:0] ADR_D = 56'h8000_0100;

  typedef struct packed {
    logic [PA-1:0] adr;
    logic [LL-1:0] line;
  } exp_t;

  typedef struct {
    logic          vv;
    logic [PA-1:0] adr;
    int            seed;
    logic [2:0]    c;
    logic          rdy;
    logic          hit;
    int            lseed;
    logic          bw;
    logic [2:0]    beat;
  } vec_t;

  logic          clk;
  logic          reset_n;
  logic          victim_valid;
  logic [PA-1:0] victim_adr;
  logic [LL-1:0] victim_line;
  logic          victim_ready;
  logic [PA-1:0] lookup_adr;
  logic          lookup_hit;
  logic [LL-1:0] lookup_line;
  logic          fetch_pending;
  logic          drain_all;
  logic          bus_write;
  logic [PA-1:0] bus_adr;
  logic [2:0]    bus_beat;
  logic [BW-1:0] bus_write_data;
  logic          bus_beat_ack = 1'b1;
  logic          empty;
  logic [2:0]    count;
  logic          ack_random = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   mon_beat = 0;
  int   lines_done = 0;
  exp_t exp_q[$];
  vec_t tbl[14];

  cache_victim_buffer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .VictimValid  (victim_valid),
    .VictimAdr    (victim_adr),
    .VictimLine   (victim_line),
    .VictimReady  (victim_ready),
    .LookupAdr    (lookup_adr),
    .LookupHit    (lookup_hit),
    .LookupLine   (lookup_line),
    .FetchPending (fetch_pending),
    .DrainAll     (drain_all),
    .BusWrite     (bus_write),
    .BusAdr       (bus_adr),
    .BusBeat      (bus_beat),
    .BusWriteData (bus_write_data),
    .BusBeatAck   (bus_beat_ack),
    .Empty        (empty),
    .Count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LL-1:0] mk_line(input int seed);
    logic [LL-1:0] l;
    l = '0;
    for (int i = 0; i < NB; i++) l[i*BW +: BW] = {32'(seed), 32'(i)};
    return l;
  endfunction

  task automatic check(input string name, input logic [LL-1:0] act, input logic [LL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    victim_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic enqueue(input logic [PA-1:0] adr, input int seed);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    victim_valid = 1'b1;
    victim_adr   = adr;
    victim_line  = mk_line(seed);
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = victim_ready;
      tick();
      n++;
    end
    victim_valid = 1'b0;
    check("enq_accept", acc, 1);
  endtask

  always @(posedge clk) begin
    #1;
    bus_beat_ack = ack_random ? ($urandom_range(3, 0) != 0) : 1'b1;
  end

  // Scoreboard: push accepted victims, compare each acked beat against the oldest one.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      mon_beat = 0;
    end else begin
      if (bus_write) begin
        check("burst_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0 && bus_beat_ack) begin
          check("bus_beat", bus_beat, mon_beat);
          check("bus_adr", bus_adr, exp_q[0].adr);
          check("bus_data", bus_write_data, exp_q[0].line[mon_beat*BW +: BW]);
          if (mon_beat == NB - 1) begin
            void'(exp_q.pop_front());
            mon_beat = 0;
            lines_done++;
          end else begin
            mon_beat++;
          end
        end
      end
      if (victim_valid && victim_ready) exp_q.push_back('{adr: victim_adr, line: victim_line});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n       = 1'b0;
    victim_valid  = 1'b0;
    victim_adr    = '0;
    victim_line   = '0;
    lookup_adr    = ADR_A;
    fetch_pending = 1'b0;
    drain_all     = 1'b0;

    // Held-fill sequence with LookupAdr = A: A(1), B(2), A(3), C(4), then D refused while full.
    tbl[0]  = '{1'b1, ADR_A, 1, 3'd1, 1'b1, 1'b1, 1, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, ADR_B, 2, 3'd2, 1'b1, 1'b1, 1, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, ADR_A, 3, 3'd3, 1'b1, 1'b1, 3, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, ADR_C, 4, 3'd4, 1'b0, 1'b1, 3, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, ADR_D, 5, 3'd4, 1'b0, 1'b1, 3, 1'b1, 3'd0};
    for (int k = 5; k <= 11; k++) tbl[k] = '{1'b1, ADR_D, 5, 3'd4, 1'b0, 1'b1, 3, 1'b1, 3'(k - 4)};
    tbl[12] = '{1'b1, ADR_D, 5, 3'd3, 1'b1, 1'b1, 3, 1'b0, 3'd0};
    tbl[13] = '{1'b0, ADR_D, 5, 3'd3, 1'b1, 1'b1, 3, 1'b0, 3'd0};

    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ready", victim_ready, 1);
    check("rst_hit", lookup_hit, 0);
    check("rst_bus_write", bus_write, 0);
    check("rst_bus_beat", bus_beat, 0);
    check("rst_bus_adr", bus_adr, 0);
    reset_n = 1'b1;
    tick();

    // Single victim, no fill pending.
    victim_valid = 1'b1;
    victim_adr   = ADR_A;
    victim_line  = mk_line(0);
    tick();
    victim_valid = 1'b0;
    check("single_bw_e1", bus_write, 0);
    check("single_count", count, 1);
    tick();
    check("single_bw_e2", bus_write, 1);
    check("single_beat0", bus_beat, 0);
    check("single_adr", bus_adr, ADR_A);
    check("single_data0", bus_write_data, 64'd0);
    repeat (7) tick();
    check("single_beat7", bus_beat, 7);
    check("single_data7", bus_write_data, 64'd7);
    check("single_not_empty", empty, 0);
    tick();
    check("single_empty", empty, 1);
    check("single_bw_done", bus_write, 0);

    // Table: fill priority, full, refused enqueue on final ack, forwarding.
    do_reset();
    fetch_pending = 1'b1;
    lookup_adr    = ADR_A;
    for (int r = 0; r < 14; r++) begin
      victim_valid = tbl[r].vv;
      victim_adr   = tbl[r].adr;
      victim_line  = mk_line(tbl[r].seed);
      tick();
      check($sformatf("row%0d_count", r), count, tbl[r].c);
      check($sformatf("row%0d_ready", r), victim_ready, tbl[r].rdy);
      check($sformatf("row%0d_hit", r), lookup_hit, tbl[r].hit);
      check($sformatf("row%0d_line", r), lookup_line, tbl[r].hit ? mk_line(tbl[r].lseed) : '0);
      check($sformatf("row%0d_bw", r), bus_write, tbl[r].bw);
      check($sformatf("row%0d_beat", r), bus_beat, tbl[r].beat);
    end
    victim_valid  = 1'b0;
    fetch_pending = 1'b0;
    n = 0;
    while (count != 3'd2 && n < 100) begin tick(); n++; end
    check("fwd_reach2", count, 2);
    check("fwd_hit_after_first", lookup_hit, 1);
    check("fwd_line_after_first", lookup_line, mk_line(3));
    n = 0;
    while (count != 3'd1 && n < 100) begin tick(); n++; end
    check("fwd_reach1", count, 1);
    check("fwd_hit_after_second", lookup_hit, 0);
    n = 0;
    while (!empty && n < 100) begin tick(); n++; end
    check("fwd_empty", empty, 1);
    check("fwd_sb_drained", exp_q.size(), 0);

    // Reset in the middle of a burst.
    do_reset();
    fetch_pending = 1'b1;
    enqueue(56'h4000_0000, 10);
    enqueue(56'h4000_0040, 11);
    enqueue(56'h4000_0080, 12);
    check("mid_count3", count, 3);
    check("mid_held", bus_write, 0);
    fetch_pending = 1'b0;
    n = 0;
    while (!(bus_write && bus_beat == 3'd3) && n < 100) begin tick(); n++; end
    check("mid_reach_beat3", bus_write && bus_beat == 3'd3, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_bw", bus_write, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_adr", bus_adr, 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("mid_after_bw", bus_write, 0);
    check("mid_after_count", count, 0);

    // Wrap-around under DrainAll with a pending fill and stalling acks.
    do_reset();
    lines_done    = 0;
    fetch_pending = 1'b1;
    drain_all     = 1'b1;
    ack_random    = 1'b1;
    for (int i = 0; i < 10; i++) enqueue(56'h1_0000_0000 + 56'(i * 64), 100 + i);
    n = 0;
    while (!empty && n < 2000) begin tick(); n++; end
    check("wrap_empty", empty, 1);
    check("wrap_lines", lines_done, 10);
    check("wrap_sb_drained", exp_q.size(), 0);
    drain_all  = 1'b0;
    ack_random = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_victim_buffer.md
Name: cache_victim_buffer

Overview:
- Parametrised multi-entry write-back buffer between the D$ and the bus interface.
- Dirty victim lines are parked here, so a line fill can proceed before the writeback completes.
- Drains entries to the bus in FIFO order, one burst per line.
- Gives read-over-write priority to pending fills and forwards buffered lines back to the cache on a lookup match.

Parameters:
- PA_BITS, 56, physical address width
- LINELEN, 512, cache line width in bits
- AHBW, 64, bus beat width in bits
- DEPTH, 4, number of victim entries (power of 2, ≥2)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- VictimValid  in  1  enqueue request
- VictimAdr  in  PA_BITS  line-aligned victim address
- VictimLine  in  LINELEN  victim line data
- VictimReady  out  1  buffer can accept an enqueue this cycle
- LookupAdr  in  PA_BITS  line address of the cache miss being checked
- LookupHit  out  1  LookupAdr matches a valid entry
- LookupLine  out  LINELEN  data of the youngest matching entry
- FetchPending  in  1  cache has a line fill waiting for the bus
- DrainAll  in  1  flush request: drain every entry regardless of FetchPending
- BusWrite  out  1  write burst in progress
- BusAdr  out  PA_BITS  head-entry line address (offset bits zero)
- BusBeat  out  log2(LINELEN/AHBW)  current beat index
- BusWriteData  out  AHBW  head-entry beat data
- BusBeatAck  in  1  bus accepted current beat
- Empty  out  1  no valid entries
- Count  out  log2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (asynchronous on reset_n low, including mid-burst):
  - all entries invalid; head, tail and Count 0
  - FSM IDLE; BusWrite 0, BusBeat 0, BusAdr 0
  - Empty 1, VictimReady 1, LookupHit 0
  - An interrupted burst is abandoned, not retried.
- Storage:
  - circular FIFO of DEPTH entries {valid, adr[PA_BITS-1:log2(LINELEN/8)], line}
  - head/tail pointers with an extra wrap bit
  - Count = tail − head, modulo 2·DEPTH
- Enqueue:
  - occurs when VictimValid & VictimReady; written at the tail and visible to lookup the next cycle
  - VictimReady = (Count != DEPTH), derived from registered state only. A same-cycle pop does not free a slot; a full buffer accepts nothing that cycle.
- Lookup:
  - combinational CAM over valid entries, tag compared at line granularity
  - Multiple matches (line re-dirtied and re-evicted): the youngest, nearest the tail, wins.
  - The entry currently draining still matches until its final beat is acked.
- Drain FSM has two states, IDLE and WRITE:
  - IDLE→WRITE when ~Empty & (~FetchPending | Count==DEPTH | DrainAll); BusBeat is set to 0.
  - In WRITE:
    - BusWrite = 1; BusAdr and BusWriteData come from the head entry, with BusWriteData = line[AHBW·BusBeat +: AHBW].
    - BusBeat increments on each BusBeatAck.
  - On BusBeatAck at the last beat: the head entry is invalidated, head increments, and the FSM returns to IDLE. This gives one idle cycle between bursts.
  - A burst, once started, is never aborted by FetchPending.
- Simultaneous enqueue and pop: both take effect and Count is unchanged. Enqueue to the slot just popped is legal after the pointer wrap.
- DrainAll is level-sensitive. The cache holds it until Empty = 1; bursts then run back-to-back with the single idle cycle between them.
- Write ordering to the bus is strict enqueue order.
- Empty = (Count == 0).

Decomposition:
- Shared package:
  - victim entry struct
  - drain state enum {VB_IDLE, VB_WRITE}
  - localparams: beats per line, offset bits, and pointer width (log2(DEPTH)+1)
- One natural sub-module, victim_cam_match: parametrised DEPTH-way tag comparator with youngest-match priority relative to head/tail. It outputs a one-hot select; the parent does an AND-OR mux of the line data.

Test Plan:
- Single victim:
  - Stimulus: after reset, enqueue adr 0x8000_0040 with FetchPending = 0; ack every cycle.
  - Response: BusWrite rises 1 cycle after enqueue; 8 beats at BusBeat 0..7 carry data words 0..7; Empty = 1 after the 8th ack.
- Fill priority:
  - Stimulus: enqueue 2 lines with FetchPending = 1.
  - Response: BusWrite stays 0 and Count = 2; the drain starts the cycle after FetchPending falls.
- Full:
  - Stimulus: enqueue 4 lines with FetchPending = 1.
  - Response: VictimReady = 0 and Count = 4; the drain starts despite FetchPending; an enqueue presented in the cycle of the final ack is refused; VictimReady = 1 the following cycle.
- Forwarding:
  - Stimulus: enqueue A (data X), then A again (data Y); LookupAdr = A.
  - Response: LookupHit = 1 and LookupLine = Y; after the first A drains, the hit persists with Y; after the second drains, LookupHit = 0.
- Reset mid-burst:
  - Stimulus: drop reset_n at beat 3 of a burst with 3 entries queued.
  - Response: BusWrite = 0 immediately, Count = 0, Empty = 1; no further bus activity after reset_n rises.
- Wrap-around and DrainAll:
  - Stimulus: 10 enqueues interleaved with drains while FetchPending = 1 and DrainAll = 1.
  - Response: all 10 addresses appear on BusAdr in enqueue order; pointers wrap with no loss.
